// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types, sizes and lane helpers for the systolic array feeder
package systolic_pkg;

    localparam int DATA_BIT_DEF = 8;
    localparam int ARRAY_N      = 4;
    localparam int STREAM_LEN   = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_OUT
    } feeder_state_t;

    // Lane n is fed at step t only while the skewed index t-n lies inside the matrix.
    function automatic logic in_window(input logic [3:0] t, input logic [1:0] lane);
        return (t >= {2'b00, lane}) && ((t - {2'b00, lane}) <= 4'd3);
    endfunction

    function automatic logic [1:0] window_idx(input logic [3:0] t, input logic [1:0] lane);
        return 2'(t - {2'b00, lane});
    endfunction

    function automatic int flat_idx(input int row, input int col);
        return row * ARRAY_N + col;
    endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// rtl/systolic_skew_gen.sv - combinational skewed lane select for the west (A rows) and north (B columns) streams
module systolic_skew_gen
    import systolic_pkg::*;
#(
    parameter int DATA_BIT = DATA_BIT_DEF
) (
    input  logic                             active,
    input  logic [3:0]                       t,
    input  logic [ARRAY_N*ARRAY_N*DATA_BIT-1:0] a_buf,
    input  logic [ARRAY_N*ARRAY_N*DATA_BIT-1:0] b_buf,
    output logic [ARRAY_N*DATA_BIT-1:0]      west,
    output logic [ARRAY_N*DATA_BIT-1:0]      north
);

    always_comb begin
        west  = '0;
        north = '0;
        for (int n = 0; n < ARRAY_N; n++) begin
            if (active && in_window(t, 2'(n))) begin
                west[n*DATA_BIT +: DATA_BIT]  =
                    a_buf[flat_idx(n, int'(window_idx(t, 2'(n))))*DATA_BIT +: DATA_BIT];
                north[n*DATA_BIT +: DATA_BIT] =
                    b_buf[flat_idx(int'(window_idx(t, 2'(n))), n)*DATA_BIT +: DATA_BIT];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - load/clear/stream/drain/output controller for a 4x4 systolic array (option: SYSTOLIC_FEEDER_TIMEOUT_EN)
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_BIT     = DATA_BIT_DEF,
    parameter int DONE_TIMEOUT = 31
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ARRAY_N*DATA_BIT-1:0]       in_row_a,
    input  logic [ARRAY_N*DATA_BIT-1:0]       in_row_b,
    output logic                              arr_rst,
    output logic [ARRAY_N*DATA_BIT-1:0]       arr_west,
    output logic [ARRAY_N*DATA_BIT-1:0]       arr_north,
    input  logic                              arr_done,
    input  logic [ARRAY_N*ARRAY_N*2*DATA_BIT-1:0] arr_result,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ARRAY_N*2*DATA_BIT-1:0]     out_row,
    output logic                              out_last,
    output logic                              busy,
    output logic                              err
);

    localparam int RW       = 2 * DATA_BIT;
    localparam int ROW_BITS = ARRAY_N * DATA_BIT;
    localparam logic [1:0] LAST_ROW = 2'(ARRAY_N - 1);
    localparam logic [3:0] LAST_T   = 4'(STREAM_LEN - 1);

    feeder_state_t state, state_n;

    logic [1:0] cnt;
    logic [1:0] r;
    logic [3:0] t;
    logic [3:0] t_n;
    logic       accept;
    logic       fire_out;
    logic       timeout;

    logic [ARRAY_N*ROW_BITS-1:0]   a_buf;
    logic [ARRAY_N*ROW_BITS-1:0]   b_buf;
    logic [ARRAY_N*ARRAY_N*RW-1:0] res_buf;
    logic [ROW_BITS-1:0]           west_n;
    logic [ROW_BITS-1:0]           north_n;

    assign accept   = in_valid & in_ready;
    assign fire_out = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (accept) state_n = S_LOAD;
            S_LOAD:   if (accept && cnt == LAST_ROW) state_n = S_CLEAR;
            S_CLEAR:  state_n = S_STREAM;
            S_STREAM: if (t == LAST_T) state_n = S_DRAIN;
            S_DRAIN:  if (arr_done || timeout) state_n = S_OUT;
            S_OUT:    if (fire_out && r == LAST_ROW) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        out_last  = 1'b0;
        arr_rst   = rst;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_LOAD:  in_ready = 1'b1;
            S_CLEAR: arr_rst = 1'b1;
            S_OUT: begin
                out_valid = 1'b1;
                out_last  = (r == LAST_ROW);
            end
            default: ;
        endcase
    end

    assign out_row = res_buf[int'(r)*ARRAY_N*RW +: ARRAY_N*RW];

    // Streams are computed from the upcoming state/step so the registered lanes line up with t.
    assign t_n = (state == S_STREAM) ? t + 4'd1 : 4'd0;

    systolic_skew_gen #(
        .DATA_BIT (DATA_BIT)
    ) u_skew (
        .active (state_n == S_STREAM),
        .t      (t_n),
        .a_buf  (a_buf),
        .b_buf  (b_buf),
        .west   (west_n),
        .north  (north_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 2'd0;
            r         <= 2'd0;
            t         <= 4'd0;
            arr_west  <= '0;
            arr_north <= '0;
        end else begin
            if (accept)   cnt <= cnt + 2'd1;
            if (fire_out) r   <= r + 2'd1;
            t         <= t_n;
            arr_west  <= west_n;
            arr_north <= north_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_buf[int'(cnt)*ROW_BITS +: ROW_BITS] <= in_row_a;
            b_buf[int'(cnt)*ROW_BITS +: ROW_BITS] <= in_row_b;
        end
        if (state == S_DRAIN && (arr_done || timeout)) res_buf <= arr_result;
    end

`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(DONE_TIMEOUT + 1);

    logic [TW-1:0] drain_cnt;
    logic          err_q;

    assign timeout = (state == S_DRAIN) && !arr_done && (drain_cnt == TW'(DONE_TIMEOUT - 1));
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + TW'(1) : '0;
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^DONE_TIMEOUT;
    assign timeout        = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench with a behavioural 4x4 output-stationary array
module tb_systolic_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_row_a;
    logic [31:0]  in_row_b;
    logic         arr_rst;
    logic [31:0]  arr_west;
    logic [31:0]  arr_north;
    logic         arr_done;
    logic [255:0] arr_result;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_row;
    logic         out_last;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    systolic_feeder #(
        .DATA_BIT     (8),
        .DONE_TIMEOUT (31)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row_a   (in_row_a),
        .in_row_b   (in_row_b),
        .arr_rst    (arr_rst),
        .arr_west   (arr_west),
        .arr_north  (arr_north),
        .arr_done   (arr_done),
        .arr_result (arr_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_last   (out_last),
        .busy       (busy),
        .err        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          a_m [4][4];
    int          b_m [4][4];
    logic [63:0] got_row [4];
    logic        got_last [4];
    bit          got_ok;

    // Behavioural array: PEs pass A east and B south, accumulating mod 2^16.
    logic [7:0]  a_pipe [4][4];
    logic [7:0]  b_pipe [4][4];
    logic [15:0] acc [4][4];
    int          k       = 0;
    int          done_at = 12;
    int          spur_at = -1;

    function automatic logic [7:0] west_in(input int i, input int j);
        if (j == 0) return arr_west[i*8 +: 8];
        return a_pipe[i][j-1];
    endfunction

    function automatic logic [7:0] north_in(input int i, input int j);
        if (i == 0) return arr_north[j*8 +: 8];
        return b_pipe[i-1][j];
    endfunction

    always @(posedge clk) begin
        if (arr_rst) begin
            k <= 0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    acc[i][j]    <= 16'd0;
                    a_pipe[i][j] <= 8'd0;
                    b_pipe[i][j] <= 8'd0;
                end
        end else begin
            k <= k + 1;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    acc[i][j]    <= acc[i][j] + 16'(west_in(i, j)) * 16'(north_in(i, j));
                    a_pipe[i][j] <= west_in(i, j);
                    b_pipe[i][j] <= north_in(i, j);
                end
        end
    end

    always_comb begin
        arr_result = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                arr_result[(4*i+j)*16 +: 16] = acc[i][j];
    end

    assign arr_done = (k == done_at) || (k == spur_at);

    function automatic logic [31:0] pack_a(input int r);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) v[c*8 +: 8] = 8'(a_m[r][c]);
        return v;
    endfunction

    function automatic logic [31:0] pack_b(input int r);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) v[c*8 +: 8] = 8'(b_m[r][c]);
        return v;
    endfunction

    function automatic logic [63:0] row64(input int c0, input int c1, input int c2, input int c3);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_job();
        for (int r = 0; r < 4; r++) begin
            in_row_a = pack_a(r);
            in_row_b = pack_b(r);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic collect_rows();
        int n;
        n         = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 300 && n < 4; c++) begin
            if (out_valid) begin
                got_row[n]  = out_row;
                got_last[n] = out_last;
                n++;
            end
            tick();
        end
        out_ready = 1'b0;
        got_ok    = (n == 4);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_row_a = '0; in_row_b = '0;
        tick(); tick();
        n_checks++; if (arr_rst !== 1'b1) begin n_fail++; $display("FAIL reset_arr_rst got=%b exp=1", arr_rst); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if ({out_valid, out_last, busy, err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {out_valid, out_last, busy, err}); end
        n_checks++; if ({arr_west, arr_north} !== 64'd0) begin n_fail++; $display("FAIL reset_streams got=%h exp=0", {arr_west, arr_north}); end
        rst = 1'b0;
        tick();
        n_checks++; if (arr_rst !== 1'b0) begin n_fail++; $display("FAIL post_reset_arr_rst got=%b exp=0", arr_rst); end
    endtask

    task automatic test_identity();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = (r == c) ? 1 : 0;
                b_m[r][c] = 4*r + c + 1;
            end
        load_job();
        n_checks++; if ({arr_rst, busy, in_ready} !== 3'b110) begin n_fail++; $display("FAIL ident_clear got=%b exp=110", {arr_rst, busy, in_ready}); end
        collect_rows();
        n_checks++; if (got_ok !== 1'b1) begin n_fail++; $display("FAIL ident_rows_timeout got=%b exp=1", got_ok); end
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (got_row[r] !== row64(4*r+1, 4*r+2, 4*r+3, 4*r+4)) begin
                n_fail++; $display("FAIL ident_row%0d got=%h exp=%h", r, got_row[r], row64(4*r+1, 4*r+2, 4*r+3, 4*r+4));
            end
        end
        n_checks++; if ({got_last[0], got_last[1], got_last[2], got_last[3]} !== 4'b0001) begin n_fail++; $display("FAIL ident_last got=%b exp=0001", {got_last[0], got_last[1], got_last[2], got_last[3]}); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ident_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_skew();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = (r << 4) | (c + 1);
                b_m[r][c] = (r == c) ? 1 : 0;
            end
        load_job();
        tick();
        n_checks++; if (arr_west !== 32'h00000001) begin n_fail++; $display("FAIL skew_west_t0 got=%h exp=00000001", arr_west); end
        n_checks++; if (arr_north !== 32'h00000001) begin n_fail++; $display("FAIL skew_north_t0 got=%h exp=00000001", arr_north); end
        tick(); tick(); tick();
        n_checks++; if (arr_west !== 32'h31221304) begin n_fail++; $display("FAIL skew_west_t3 got=%h exp=31221304", arr_west); end
        tick(); tick(); tick();
        n_checks++; if (arr_north !== 32'h01000000) begin n_fail++; $display("FAIL skew_north_t6 got=%h exp=01000000", arr_north); end
        tick(); tick(); tick();
        n_checks++; if (arr_west !== 32'h00000000) begin n_fail++; $display("FAIL skew_west_t9 got=%h exp=00000000", arr_west); end
        collect_rows();
        n_checks++; if (got_ok !== 1'b1) begin n_fail++; $display("FAIL skew_rows_timeout got=%b exp=1", got_ok); end
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (got_row[r] !== row64((r<<4)|1, (r<<4)|2, (r<<4)|3, (r<<4)|4)) begin
                n_fail++; $display("FAIL skew_row%0d got=%h exp=%h", r, got_row[r], row64((r<<4)|1, (r<<4)|2, (r<<4)|3, (r<<4)|4));
            end
        end
    endtask

    task automatic test_saturate();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = 255;
                b_m[r][c] = 255;
            end
        load_job();
        collect_rows();
        n_checks++; if (got_ok !== 1'b1) begin n_fail++; $display("FAIL sat_rows_timeout got=%b exp=1", got_ok); end
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (got_row[r] !== {4{16'hF804}}) begin n_fail++; $display("FAIL sat_row%0d got=%h exp=%h", r, got_row[r], {4{16'hF804}}); end
        end
    endtask

    task automatic test_load_gaps();
        int pulses;
        pulses = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = 1;
                b_m[r][c] = r + 1;
            end
        for (int r = 0; r < 4; r++) begin
            in_row_a = pack_a(r);
            in_row_b = pack_b(r);
            in_valid = 1'b1;
            tick();
            if (arr_rst) pulses++;
            in_valid = 1'b0;
            in_row_a = '1;
            in_row_b = '1;
            tick();
            if (arr_rst) pulses++;
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (arr_rst) pulses++;
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL gaps_clear_pulses got=%0d exp=1", pulses); end
        collect_rows();
        n_checks++; if (got_ok !== 1'b1) begin n_fail++; $display("FAIL gaps_rows_timeout got=%b exp=1", got_ok); end
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (got_row[r] !== row64(10, 10, 10, 10)) begin n_fail++; $display("FAIL gaps_row%0d got=%h exp=%h", r, got_row[r], row64(10, 10, 10, 10)); end
        end
    endtask

    task automatic test_backpressure();
        int waited;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = r + c;
                b_m[r][c] = (r == c) ? 1 : 0;
            end
        spur_at = 4;
        load_job();
        waited = 0;
        while (!out_valid && waited < 200) begin
            tick();
            waited++;
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({out_valid, out_last, out_row} !== {2'b10, row64(0, 1, 2, 3)}) begin
                n_fail++; $display("FAIL bp_hold_cycle%0d got=%b%b_%h exp=10_%h", c, out_valid, out_last, out_row, row64(0, 1, 2, 3));
            end
            tick();
        end
        collect_rows();
        spur_at = -1;
        n_checks++; if (got_ok !== 1'b1) begin n_fail++; $display("FAIL bp_rows_timeout got=%b exp=1", got_ok); end
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (got_row[r] !== row64(r, r+1, r+2, r+3)) begin n_fail++; $display("FAIL bp_row%0d got=%h exp=%h", r, got_row[r], row64(r, r+1, r+2, r+3)); end
        end
    endtask

    task automatic test_rst_mid();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = (r == c) ? 1 : 0;
                b_m[r][c] = 4*r + c + 1;
            end
        load_job();
        for (int c = 0; c < 6; c++) tick();
        rst = 1'b1;
        tick();
        n_checks++; if ({in_ready, out_valid, busy, arr_rst} !== 4'b1001) begin n_fail++; $display("FAIL rstmid_flags got=%b exp=1001", {in_ready, out_valid, busy, arr_rst}); end
        n_checks++; if (arr_west !== 32'd0) begin n_fail++; $display("FAIL rstmid_west got=%h exp=0", arr_west); end
        rst = 1'b0;
        tick();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) a_m[r][c] = (r == c) ? 2 : 0;
        load_job();
        collect_rows();
        n_checks++; if (got_ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_rows_timeout got=%b exp=1", got_ok); end
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (got_row[r] !== row64(8*r+2, 8*r+4, 8*r+6, 8*r+8)) begin
                n_fail++; $display("FAIL rstmid_row%0d got=%h exp=%h", r, got_row[r], row64(8*r+2, 8*r+4, 8*r+6, 8*r+8));
            end
        end
    endtask

`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = (r == c) ? 1 : 0;
                b_m[r][c] = 4*r + c + 1;
            end
        done_at = 1000000;
        load_job();
        for (int c = 0; c < 41; c++) tick();
        n_checks++; if ({out_valid, err} !== 2'b00) begin n_fail++; $display("FAIL tmo_before got=%b exp=00", {out_valid, err}); end
        tick();
        n_checks++; if ({out_valid, err} !== 2'b11) begin n_fail++; $display("FAIL tmo_after got=%b exp=11", {out_valid, err}); end
        collect_rows();
        done_at = 12;
        n_checks++; if (got_ok !== 1'b1) begin n_fail++; $display("FAIL tmo_rows_timeout got=%b exp=1", got_ok); end
        n_checks++; if (got_row[2] !== row64(9, 10, 11, 12)) begin n_fail++; $display("FAIL tmo_row2 got=%h exp=%h", got_row[2], row64(9, 10, 11, 12)); end
        n_checks++; if ({busy, err} !== 2'b01) begin n_fail++; $display("FAIL tmo_sticky got=%b exp=01", {busy, err}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_cleared got=%b exp=0", err); end
    endtask
`else
    task automatic test_no_timeout();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = (r == c) ? 1 : 0;
                b_m[r][c] = 4*r + c + 1;
            end
        done_at = 60;
        load_job();
        for (int c = 0; c < 50; c++) tick();
        n_checks++; if ({out_valid, err, busy} !== 3'b001) begin n_fail++; $display("FAIL wait_drain got=%b exp=001", {out_valid, err, busy}); end
        collect_rows();
        done_at = 12;
        n_checks++; if (got_ok !== 1'b1) begin n_fail++; $display("FAIL wait_rows_timeout got=%b exp=1", got_ok); end
        n_checks++; if (got_row[3] !== row64(13, 14, 15, 16)) begin n_fail++; $display("FAIL wait_row3 got=%h exp=%h", got_row[3], row64(13, 14, 15, 16)); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wait_err got=%b exp=0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_identity();
        test_skew();
        test_saturate();
        test_load_gaps();
        test_backpressure();
        test_rst_mid();
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
